vga_timing_gen: RTL

- Downstream stage of the colour multiplexer in the VGA driver.
- Generates 640x480@60 Hz horizontal/vertical timing from a pixel-rate enable.
- Publishes the current pixel coordinates to the pattern functions.
- Samples the selected DATA_WIDTH colour and drives registered, blank-gated RGB aligned with hsync/vsync to the DAC.

---
 rtl/vga_pkg.sv | 48 ++++
 rtl/vga_axis_counter.sv | 55 +++++
 rtl/vga_timing_gen.sv | 101 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Purpose : shared timing constants, axis state encoding and test-bar colours for the VGA timing generator.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package vga_pkg;

    // Default 640x480@60 Hz timing (pixels / lines).
    localparam int VGA_DATA_WIDTH = 24;
    localparam int VGA_H_ACTIVE   = 640;
    localparam int VGA_H_FP       = 16;
    localparam int VGA_H_SYNC     = 96;
    localparam int VGA_H_BP       = 48;
    localparam int VGA_V_ACTIVE   = 480;
    localparam int VGA_V_FP       = 10;
    localparam int VGA_V_SYNC     = 2;
    localparam int VGA_V_BP       = 33;
    localparam int VGA_H_TOTAL    = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL    = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Region of one axis (horizontal or vertical) within its period.
    typedef enum logic [1:0] {ACT, FP, SYNC, BP} sync_state_t;

    // Test-bar colours, {R, G, B}, each channel fully on or off.
    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    // Maps a 3-bit bar index to its colour.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Purpose : one timing axis - position counter plus ACT/FP/SYNC/BP region FSM.
// Latency : count/state update on the clk edge where step = 1; wrap is combinational.
// Backpressure: none; holds all state while step = 0.
// Ports: clk, reset (async active-low), step (advance enable) ->
//        count (0..TOTAL-1), state (region of count), wrap (this step returns count to 0).
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE_LEN = 640,
    parameter int FP_LEN     = 16,
    parameter int SYNC_LEN   = 96,
    parameter int BP_LEN     = 48
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  step,
    output logic [$clog2(ACTIVE_LEN+FP_LEN+SYNC_LEN+BP_LEN)-1:0] count,
    output sync_state_t                                           state,
    output logic                                                  wrap
);

    localparam int TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;
    localparam int W     = $clog2(TOTAL);

    // Last count of each region; the state moves on when stepping off it.
    localparam logic [W-1:0] LAST_ACT  = W'(ACTIVE_LEN - 1);
    localparam logic [W-1:0] LAST_FP   = W'(ACTIVE_LEN + FP_LEN - 1);
    localparam logic [W-1:0] LAST_SYNC = W'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
    localparam logic [W-1:0] LAST_ALL  = W'(TOTAL - 1);

    assign wrap = step && (count == LAST_ALL);

    // State is registered alongside count so it always describes the current count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            state <= ACT;
        end else if (step) begin
            if (wrap) begin
                count <= '0;
                state <= ACT;
            end else begin
                count <= count + 1'b1;
                case (state)
                    ACT:     if (count == LAST_ACT)  state <= FP;
                    FP:      if (count == LAST_FP)   state <= SYNC;
                    SYNC:    if (count == LAST_SYNC) state <= BP;
                    BP:      state <= BP;
                    default: state <= ACT;
                endcase
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose : 640x480@60 timing generator; publishes x/y, drives registered sync/blank/RGB to the DAC.
// Latency : one pix_en from (x_pos, y_pos) to the matching hsync/vsync/blank_n/rgb_out.
// Backpressure: none; everything except frame_start holds while pix_en = 0.
// Ports: clk, reset (async active-low), pix_en, color_in -> x_pos, y_pos, active,
//        hsync, vsync, blank_n, rgb_out, frame_start.
// Option: VGA_TEST_PATTERN_EN adds input test_en selecting an internal 8-bar pattern.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int DATA_WIDTH = VGA_DATA_WIDTH,
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP
) (
    input  logic                                              clk,
    input  logic                                              reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                                              test_en,
`endif
    input  logic                                              pix_en,
    input  logic [DATA_WIDTH-1:0]                             color_in,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]      x_pos,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]      y_pos,
    output logic                                              active,
    output logic                                              hsync,
    output logic                                              vsync,
    output logic                                              blank_n,
    output logic [DATA_WIDTH-1:0]                             rgb_out,
    output logic                                              frame_start
);

    sync_state_t           h_state;
    sync_state_t           v_state;
    logic                  h_wrap;
    logic                  v_wrap;
    logic [DATA_WIDTH-1:0] pix_colour;

    vga_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE),
        .FP_LEN     (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BP_LEN     (H_BP)
    ) u_h_axis (
        .clk   (clk),
        .reset (reset),
        .step  (pix_en),
        .count (x_pos),
        .state (h_state),
        .wrap  (h_wrap)
    );

    // The vertical axis steps once per line, i.e. on the horizontal wrap.
    vga_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE),
        .FP_LEN     (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BP_LEN     (V_BP)
    ) u_v_axis (
        .clk   (clk),
        .reset (reset),
        .step  (h_wrap),
        .count (y_pos),
        .state (v_state),
        .wrap  (v_wrap)
    );

    assign active = (h_state == ACT) && (v_state == ACT);

`ifdef VGA_TEST_PATTERN_EN
    // Eight 128-pixel bars; only indices 0..4 fall inside the visible width.
    assign pix_colour = test_en ? DATA_WIDTH'(bar_colour(x_pos[9:7])) : color_in;
`else
    assign pix_colour = color_in;
`endif

    // Output stage: sync, blank and colour of one pixel leave on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            rgb_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            // v_wrap already implies pix_en and h_wrap, so this is a one-clk pulse.
            frame_start <= v_wrap;
            if (pix_en) begin
                hsync   <= !(h_state == SYNC);
                vsync   <= !(v_state == SYNC);
                blank_n <= active;
                rgb_out <= active ? pix_colour : '0;
            end
        end
    end

endmodule
